// File: rtl/uart_8250_rx_peer.sv
// Serial receiver acting as link partner of uart_8250: 16x oversampled start/data/parity/stop
// recovery with 8250 divisor/LCR encoding and a valid/acknowledge character output.
`timescale 1ns/1ps
module uart_8250_rx_peer #(
    parameter logic [15:0] DIV_RST = 16'd1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [15:0] DIV_I,
    input  logic [5:0]  LCR_I,
    input  logic        RXD_I,
    input  logic        ACK_I,
    output logic [7:0]  DAT_O,
    output logic        VLD_O,
    output logic        PE_O,
    output logic        FE_O,
    output logic        BI_O,
    output logic        OE_O,
    output logic        BUSY_O
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_BRKWAIT = 3'd5;

    logic        rx_meta_q, rxs_q;
    logic [15:0] cnt_q, cnt_d, div_q, div_d, div_eff;
    logic [2:0]  state_q, state_d, bit_q, bit_d, last_bit;
    logic [3:0]  tcnt_q, tcnt_d;
    logic [7:0]  shr_q, shr_d, dat_q, dat_d;
    logic [4:0]  lcr_q, lcr_d;
    logic        par_q, par_d, pbad_q, pbad_d, par_exp, brk, tick, done;
    logic        vld_q, vld_d, pe_q, pe_d, fe_q, fe_d, bi_q, bi_d, oe_q, oe_d;
    logic        unused_lcr_stb;

    // A receiver checks only the first stop bit, so the stop-bit count is irrelevant.
    assign unused_lcr_stb = LCR_I[2];

    // The divisor is frozen for the duration of a frame.
    assign div_eff  = (state_q == S_IDLE) ? DIV_I : div_q;
    assign tick     = (div_eff != 16'd0) && (cnt_q == 16'd0);
    assign last_bit = 3'd4 + {1'b0, lcr_q[1:0]};
    assign par_exp  = lcr_q[4] ? ~lcr_q[3] : ((^shr_q) ^ ~lcr_q[3]);
    assign brk      = (shr_q == 8'd0) && !par_q && !rxs_q;

    always_comb begin
        if (div_eff == 16'd0)    cnt_d = cnt_q;
        else if (cnt_q == 16'd0) cnt_d = div_eff - 16'd1;
        else                     cnt_d = cnt_q - 16'd1;
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bit_d   = bit_q;
        shr_d   = shr_q;
        par_d   = par_q;
        pbad_d  = pbad_q;
        div_d   = div_q;
        lcr_d   = lcr_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && !rxs_q) begin
                    state_d = S_START;
                    tcnt_d  = 4'd0;
                    bit_d   = 3'd0;
                    shr_d   = 8'd0;
                    par_d   = 1'b0;
                    pbad_d  = 1'b0;
                    div_d   = DIV_I;
                    lcr_d   = {LCR_I[5:3], LCR_I[1:0]};
                end
            end
            S_START: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd7) begin
                        tcnt_d  = 4'd0;
                        state_d = rxs_q ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        shr_d[bit_q] = rxs_q;
                        if (bit_q == last_bit) state_d = lcr_q[2] ? S_PARITY : S_STOP;
                        else                   bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        par_d   = rxs_q;
                        pbad_d  = rxs_q ^ par_exp;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        done    = 1'b1;
                        state_d = brk ? S_BRKWAIT : S_IDLE;
                    end
                end
            end
            S_BRKWAIT: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (DIV_I == 16'd0) begin
            state_d = S_IDLE;
            done    = 1'b0;
        end
    end

    // A completion in the same cycle as an acknowledge replaces the old character cleanly.
    always_comb begin
        vld_d = vld_q;
        oe_d  = oe_q;
        dat_d = dat_q;
        pe_d  = pe_q;
        fe_d  = fe_q;
        bi_d  = bi_q;
        if (ACK_I && vld_q) begin
            vld_d = 1'b0;
            oe_d  = 1'b0;
        end
        if (done) begin
            vld_d = 1'b1;
            if (vld_q && !ACK_I) oe_d = 1'b1;
            dat_d = shr_q;
            pe_d  = pbad_q;
            fe_d  = ~rxs_q;
            bi_d  = brk;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            cnt_q     <= DIV_RST - 16'd1;
            state_q   <= S_IDLE;
            tcnt_q    <= 4'd0;
            bit_q     <= 3'd0;
            shr_q     <= 8'd0;
            par_q     <= 1'b0;
            pbad_q    <= 1'b0;
            div_q     <= 16'd0;
            lcr_q     <= 5'd0;
            dat_q     <= 8'd0;
            vld_q     <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            rx_meta_q <= RXD_I;
            rxs_q     <= rx_meta_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bit_q     <= bit_d;
            shr_q     <= shr_d;
            par_q     <= par_d;
            pbad_q    <= pbad_d;
            div_q     <= div_d;
            lcr_q     <= lcr_d;
            dat_q     <= dat_d;
            vld_q     <= vld_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
            oe_q      <= oe_d;
        end
    end

    assign DAT_O  = dat_q;
    assign VLD_O  = vld_q;
    assign PE_O   = pe_q;
    assign FE_O   = fe_q;
    assign BI_O   = bi_q;
    assign OE_O   = oe_q;
    assign BUSY_O = (state_q != S_IDLE);
endmodule
